ram_port_arbiter: RTL and testbench
===================================

# ram_port_arbiter

Round-robin arbiter that shares one `single_port_ram` instance between `N_REQ` requesters, e.g. the SPI slave front-end and the processor datapath. It accepts one access per grant, drives the RAM port for exactly one cycle, and returns read data with a registered valid pulse. It sits between the requesters and the RAM's port interface and is the only driver of that port.

## Interface
- `N_REQ`, 2, number of requesters (≥2)
- `ADDR_WIDTH`, 8, RAM address width; matches the RAM
- `DATA_WIDTH`, 32, RAM data width; matches the RAM
- `clk`  in  1  single clock; all state on rising edge
- `rst`  in  1  synchronous, active-high reset
- `req_i`  in  N_REQ  per-requester access request; held high until own `gnt_o` seen
- `we_i`  in  N_REQ  per-requester write enable; stable while `req_i` high
- `addr_i`  in  N_REQ*ADDR_WIDTH  packed addresses, requester k at `[k*ADDR_WIDTH +: ADDR_WIDTH]`
- `wdata_i`  in  N_REQ*DATA_WIDTH  packed write data, same packing
- `gnt_o`  out  N_REQ  one-hot grant pulse, one cycle
- `rvalid_o`  out  N_REQ  one-hot read-data-valid pulse, reads only
- `rdata_o`  out  DATA_WIDTH  read data shared by all requesters, qualified by `rvalid_o`
- `ram`  `single_port_ram_port_if.CTRL` modport: drives `en`, `we`, `addr`, `wdata`; receives combinational `rdata`

## Operation
- FSM states: `IDLE`, `ACCESS`.
- `IDLE`: if any `req_i` high, pick winner w by round-robin starting at `last+1` (mod N_REQ), latch `we_i[w]`, `addr_i[w]`, `wdata_i[w]`, set `last <= w`, go to `ACCESS`. No request: stay in `IDLE`, all outputs inactive.
- `ACCESS`: `gnt_o[w]=1`; RAM port driven from latched fields with `en=1`, `we=latched we`. Write commits at the end of this cycle. On a read, `rdata_o <= ram.rdata` and `rvalid_o[w] <= 1` at the end of the cycle. Next state is always `IDLE`.
- Requesters drop `req_i` on the edge that ends their `gnt_o` cycle. A `req_i` still high in the following `IDLE` is treated as a new request.
- Round-robin: the last winner has lowest priority next arbitration. With a single active requester, it is granted every arbitration.
- `req_i` changes during `ACCESS` are ignored; only `IDLE` samples.
- `rdata_o` holds its last read value until the next read completes. Writes never update `rdata_o` and never pulse `rvalid_o`.

## Timing
- Request sampled in `IDLE` cycle T → `gnt_o` and RAM `en` in T+1 → `rvalid_o`/`rdata_o` in T+2.
- Peak throughput: one access per 2 cycles. A new `IDLE` arbitration occurs in T+2, concurrent with `rvalid_o` from the previous read.
- Reset values: state `IDLE`, `last = N_REQ-1` (requester 0 wins first), `gnt_o=0`, `rvalid_o=0`, `rdata_o=0`, `ram.en=0`, `ram.we=0`, `ram.addr=0`, `ram.wdata=0`.
- RAM `en`/`we` are gated by `!rst`: a cycle with `rst` high never writes the RAM, including `rst` asserted mid-`ACCESS`. Such an access is dropped with no `rvalid_o`.
- `gnt_o`, `rvalid_o`, and RAM port signals are glitch-free functions of registered state only; there are no combinational paths from `req_i` to any output.

## Structure
- Package `ram_arb_pkg`: `state_t` enum (`IDLE`, `ACCESS`).
- Sub-module `rr_arbiter`: purely combinational, parameterised by `N_REQ`. Inputs are `req` and `last`; outputs are a one-hot `grant` and an index `grant_idx`. The FSM, latch registers, and RAM port drive stay in `ram_port_arbiter`.

## Test plan
- Reset: hold `rst` 2 cycles with `req_i=2'b11` → no `gnt_o`, `ram.en=0` throughout; after release, requester 0 granted first.
- Write then read, requester 1 alone: write 0xDEADBEEF to addr 0x10, then read addr 0x10 → `gnt_o=2'b10` each time; `rvalid_o=2'b10`, `rdata_o=0xDEADBEEF` exactly 2 cycles after sampling; no `rvalid_o` on the write.
- Contention: both requesters issue continuous reads to 0x01 and 0x02 → grants alternate 0,1,0,1; each `rdata_o` matches its own address contents.
- Single persistent requester: requester 0 re-requests immediately after every grant → granted on every `IDLE`, one grant per 2 cycles.
- Reset mid-access: assert `rst` in the `ACCESS` cycle of a write of 0x55 to addr 0x20, which previously held 0x00 → subsequent read of 0x20 returns 0x00; no `rvalid_o` for the aborted access.

Source files
------------

// File: rtl/ram_port_arbiter_pkg.sv
// Shared types for the RAM port arbiter.
// The FSM only has an arbitration cycle and a RAM access cycle.
package ram_arb_pkg;

   typedef enum logic {
      IDLE   = 1'b0,
      ACCESS = 1'b1
   } state_t;

endpackage

// File: rtl/ram_port_arbiter_if.sv
// Port bundle of a single-port RAM with a combinational read path.
// CTRL is the controlling side and RAM the memory side.
interface single_port_ram_port_if #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 32
);
   logic                  en;
   logic                  we;
   logic [ADDR_WIDTH-1:0] addr;
   logic [DATA_WIDTH-1:0] wdata;
   logic [DATA_WIDTH-1:0] rdata;

   modport CTRL (output en, output we, output addr, output wdata, input rdata);
   modport RAM  (input en, input we, input addr, input wdata, output rdata);
endinterface

// File: rtl/ram_port_arbiter_rr.sv
// Combinational round-robin pick. The requester after 'last' has the
// highest priority, and 'last' itself has the lowest.
module rr_arbiter #(
   parameter  int N_REQ = 2,
   localparam int IDX_W = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [IDX_W-1:0] last,
   output logic [N_REQ-1:0] grant,
   output logic [IDX_W-1:0] grant_idx
);
   logic [N_REQ-1:0] upper_mask;
   logic [N_REQ-1:0] masked_req;
   logic [N_REQ-1:0] pick_src;

   // Requesters above 'last' go first; wrap to the full vector if none is active.
   for (genvar gi = 0; gi < N_REQ; gi++) begin : g_mask
      assign upper_mask[gi] = (gi > int'(last));
   end

   assign masked_req = req & upper_mask;
   assign pick_src   = (|masked_req) ? masked_req : req;
   assign grant      = pick_src & (~pick_src + N_REQ'(1));

   always_comb begin
      grant_idx = '0;
      for (int k = 0; k < N_REQ; k++) begin
         if (grant[k]) begin
            grant_idx = grant_idx | IDX_W'(k);
         end
      end
   end
endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one single-port RAM between N_REQ requesters: arbitrate in IDLE,
// drive the RAM for one ACCESS cycle, return read data one cycle later.
module ram_port_arbiter
   import ram_arb_pkg::*;
#(
   parameter  int N_REQ      = 2,
   parameter  int ADDR_WIDTH = 8,
   parameter  int DATA_WIDTH = 32,
   localparam int IDX_W      = $clog2(N_REQ)
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [N_REQ-1:0]            req_i,
   input  logic [N_REQ-1:0]            we_i,
   input  logic [N_REQ*ADDR_WIDTH-1:0] addr_i,
   input  logic [N_REQ*DATA_WIDTH-1:0] wdata_i,
   output logic [N_REQ-1:0]            gnt_o,
   output logic [N_REQ-1:0]            rvalid_o,
   output logic [DATA_WIDTH-1:0]       rdata_o,
   single_port_ram_port_if.CTRL        ram
);
   state_t                state_q;
   logic [IDX_W-1:0]      last_q;
   logic [N_REQ-1:0]      gnt_q;
   logic [N_REQ-1:0]      rvalid_q;
   logic [DATA_WIDTH-1:0] rdata_q;
   logic                  en_q;
   logic                  we_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [DATA_WIDTH-1:0] wdata_q;

   logic [N_REQ-1:0]      win_onehot;
   logic [IDX_W-1:0]      win_idx;
   logic [ADDR_WIDTH-1:0] addr_arr  [N_REQ];
   logic [DATA_WIDTH-1:0] wdata_arr [N_REQ];

   for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
      assign addr_arr[gi]  = addr_i[gi*ADDR_WIDTH +: ADDR_WIDTH];
      assign wdata_arr[gi] = wdata_i[gi*DATA_WIDTH +: DATA_WIDTH];
   end

   rr_arbiter #(.N_REQ(N_REQ)) u_rr (
      .req       (req_i),
      .last      (last_q),
      .grant     (win_onehot),
      .grant_idx (win_idx)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         last_q   <= IDX_W'(N_REQ - 1);
         gnt_q    <= '0;
         rvalid_q <= '0;
         rdata_q  <= '0;
         en_q     <= 1'b0;
         we_q     <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
      end else begin
         rvalid_q <= '0;
         case (state_q)
            IDLE: begin
               gnt_q <= '0;
               en_q  <= 1'b0;
               if (|req_i) begin
                  state_q <= ACCESS;
                  last_q  <= win_idx;
                  gnt_q   <= win_onehot;
                  en_q    <= 1'b1;
                  we_q    <= we_i[win_idx];
                  addr_q  <= addr_arr[win_idx];
                  wdata_q <= wdata_arr[win_idx];
               end
            end
            ACCESS: begin
               state_q <= IDLE;
               gnt_q   <= '0;
               en_q    <= 1'b0;
               if (!we_q) begin
                  rvalid_q <= gnt_q;
                  rdata_q  <= ram.rdata;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign gnt_o     = gnt_q;
   assign rvalid_o  = rvalid_q;
   assign rdata_o   = rdata_q;
   // A reset arriving mid-access must never reach the RAM as a write.
   assign ram.en    = en_q & ~rst;
   assign ram.we    = en_q & we_q & ~rst;
   assign ram.addr  = addr_q;
   assign ram.wdata = wdata_q;
endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter with a behavioural combinational-read RAM.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_ram_port_arbiter;
   localparam int N_REQ = 2;
   localparam int AW    = 8;
   localparam int DW    = 32;

   logic                  clk = 1'b0;
   logic                  rst;
   logic [N_REQ-1:0]      req;
   logic [N_REQ-1:0]      we;
   logic [N_REQ*AW-1:0]   addr;
   logic [N_REQ*DW-1:0]   wdata;
   logic [N_REQ-1:0]      gnt;
   logic [N_REQ-1:0]      rvalid;
   logic [DW-1:0]         rdata;

   logic [DW-1:0] mem [256];
   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   single_port_ram_port_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) ram_if ();

   assign ram_if.rdata = mem[ram_if.addr];
   always @(posedge clk) begin
      if (ram_if.en && ram_if.we) mem[ram_if.addr] <= ram_if.wdata;
   end

   ram_port_arbiter #(.N_REQ(N_REQ), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .clk      (clk),
      .rst      (rst),
      .req_i    (req),
      .we_i     (we),
      .addr_i   (addr),
      .wdata_i  (wdata),
      .gnt_o    (gnt),
      .rvalid_o (rvalid),
      .rdata_o  (rdata),
      .ram      (ram_if)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_port(input int k, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
      we[k]              = w;
      addr[k*AW +: AW]   = a;
      wdata[k*DW +: DW]  = d;
   endtask

   logic [DW-1:0] exp_rd [N_REQ];

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = '0;
      mem[8'h01] = 32'h1111_0001;
      mem[8'h02] = 32'h2222_0002;
      exp_rd[0]  = 32'h1111_0001;
      exp_rd[1]  = 32'h2222_0002;

      // Reset held two cycles with both requesting.
      rst = 1'b1; req = 2'b11; we = '0; addr = '0; wdata = '0;
      set_port(0, 1'b0, 8'h01, '0);
      set_port(1, 1'b0, 8'h02, '0);
      for (int i = 0; i < 2; i++) begin
         tick();
         check("rst_gnt", 64'(gnt), 64'h0);
         check("rst_en", 64'(ram_if.en), 64'h0);
      end
      check("rst_rvalid", 64'(rvalid), 64'h0);
      check("rst_rdata", 64'(rdata), 64'h0);
      check("rst_addr", 64'(ram_if.addr), 64'h0);
      rst = 1'b0;

      // Requester 0 wins first after reset, then requester 1.
      tick();
      check("first_gnt", 64'(gnt), 64'h1);
      check("first_en", 64'(ram_if.en), 64'h1);
      check("first_addr", 64'(ram_if.addr), 64'h01);
      req = 2'b10;
      tick();
      check("first_rvalid", 64'(rvalid), 64'h1);
      check("first_rdata", 64'(rdata), 64'h1111_0001);
      $display("txn rd req0 addr 01 data %08h", rdata);
      tick();
      check("second_gnt", 64'(gnt), 64'h2);
      req = 2'b00;
      tick();
      check("second_rvalid", 64'(rvalid), 64'h2);
      check("second_rdata", 64'(rdata), 64'h2222_0002);
      $display("txn rd req1 addr 02 data %08h", rdata);

      // Requester 1 alone: write DEADBEEF to 0x10, then read it back.
      req = 2'b10;
      set_port(1, 1'b1, 8'h10, 32'hDEAD_BEEF);
      tick();
      check("wr_gnt", 64'(gnt), 64'h2);
      check("wr_we", 64'(ram_if.we), 64'h1);
      check("wr_addr", 64'(ram_if.addr), 64'h10);
      check("wr_wdata", 64'(ram_if.wdata), 64'hDEAD_BEEF);
      req = 2'b00;
      tick();
      check("wr_no_rvalid", 64'(rvalid), 64'h0);
      check("wr_rdata_hold", 64'(rdata), 64'h2222_0002);
      $display("txn wr req1 addr 10 data deadbeef");
      req = 2'b10;
      set_port(1, 1'b0, 8'h10, '0);
      tick();
      check("rd10_gnt", 64'(gnt), 64'h2);
      check("rd10_we", 64'(ram_if.we), 64'h0);
      req = 2'b00;
      tick();
      check("rd10_rvalid", 64'(rvalid), 64'h2);
      check("rd10_rdata", 64'(rdata), 64'hDEAD_BEEF);
      $display("txn rd req1 addr 10 data %08h", rdata);

      // Contention: continuous reads, grants must alternate 0,1,0,1.
      set_port(0, 1'b0, 8'h01, '0);
      set_port(1, 1'b0, 8'h02, '0);
      req = 2'b11;
      for (int i = 0; i < 4; i++) begin
         tick();
         check("rr_gnt", 64'(gnt), 64'(1 << (i % 2)));
         tick();
         check("rr_rvalid", 64'(rvalid), 64'(1 << (i % 2)));
         check("rr_rdata", 64'(rdata), 64'(exp_rd[i % 2]));
         $display("txn rd req%0d data %08h", i % 2, rdata);
      end
      req = 2'b00;

      // Single persistent requester 0: one grant every two cycles.
      req = 2'b01;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("solo_gnt", 64'(gnt), 64'h1);
         tick();
         check("solo_idle_gnt", 64'(gnt), 64'h0);
         check("solo_rvalid", 64'(rvalid), 64'h1);
         $display("txn rd req0 addr 01 data %08h", rdata);
      end
      req = 2'b00;
      tick();

      // Reset in the ACCESS cycle of a write of 0x55 to 0x20.
      req = 2'b01;
      set_port(0, 1'b1, 8'h20, 32'h0000_0055);
      tick();
      check("abort_gnt", 64'(gnt), 64'h1);
      rst = 1'b1;
      req = 2'b00;
      #1;
      check("abort_en_gated", 64'(ram_if.en), 64'h0);
      tick();
      rst = 1'b0;
      check("abort_rvalid", 64'(rvalid), 64'h0);
      check("abort_gnt_clr", 64'(gnt), 64'h0);
      $display("txn wr req0 addr 20 aborted by reset");
      tick();
      req = 2'b01;
      set_port(0, 1'b0, 8'h20, '0);
      tick();
      check("post_gnt", 64'(gnt), 64'h1);
      req = 2'b00;
      tick();
      check("post_rvalid", 64'(rvalid), 64'h1);
      check("post_rdata", 64'(rdata), 64'h0);
      $display("txn rd req0 addr 20 data %08h", rdata);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
